// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: FSM states,
// parity and data-bits encodings, and the received-word bundle.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [1:0] PRTY_NONE = 2'b00;
    localparam logic [1:0] PRTY_ODD  = 2'b01;
    localparam logic [1:0] PRTY_EVEN = 2'b10;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_word_t;

    function automatic logic [3:0] data_width(
        input logic [1:0] sel
    );
        logic [3:0] w;
        case (sel)
            DBITS_5: w = 4'd5;
            DBITS_6: w = 4'd6;
            DBITS_7: w = 4'd7;
            DBITS_8: w = 4'd8;
            default: w = 4'd8;
        endcase
        return w;
    endfunction

    function automatic logic prty_en(
        input logic [1:0] sel
    );
        return (sel == PRTY_ODD) || (sel == PRTY_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with registered pointers/count.
// Ports: clk, rst (async high), push/din, pop, dout, valid (!empty), ovr pulse.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         ovr
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
        end else begin
            ovr <= push && !do_push;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = empty ? '0 : mem[rd_ptr];
    assign valid = !empty;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: sync, tick generator, majority-vote FSM.
// Ports: clk, rst, baud_div, data_bits, prty_sel, stop_sel, rx_in,
//   rx_data/rx_valid/rx_ready, err_prty, err_frame, brk_det, err_ovr, busy.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH FIFO instead of one holding reg.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OSR        = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic [1:0]       prty_sel,
    input  logic             stop_sel,
    input  logic             rx_in,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             err_prty,
    output logic             err_frame,
    output logic             brk_det,
    output logic             err_ovr,
    output logic             busy
);

    if (OSR < 8 || (OSR % 2) != 0) begin : g_bad_osr
        $error("OSR must be even and >= 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2");
    end

    localparam int OS_W = $clog2(OSR);
    localparam logic [OS_W-1:0] S0 = OS_W'(OSR/2 - 1);
    localparam logic [OS_W-1:0] S1 = OS_W'(OSR/2);
    localparam logic [OS_W-1:0] S2 = OS_W'(OSR/2 + 1);
    localparam logic [OS_W-1:0] SL = OS_W'(OSR - 1);

    // Synchroniser plus one extra stage for edge detection.
    logic rx_s1;
    logic rx_s2;
    logic rx_d3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d3 <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            rx_d3 <= rx_s2;
        end
    end

    rx_state_t        state;
    logic             arm;
    logic             start_det;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    // arm stays low after a framing error until the line is seen high.
    assign start_det = (state == IDLE) && arm && rx_d3 && !rx_s2;
    assign tick      = (div_cnt == baud_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (start_det || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    logic [OS_W-1:0] os_cnt;
    logic [1:0]      smp;
    logic            mid;
    logic            maj;
    logic [2:0]      bit_cnt;
    logic [2:0]      cfg_last;
    logic [1:0]      cfg_prty;
    logic            cfg_stop2;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            ones;
    logic            ferr;
    logic            stop_cnt;
    logic            push;
    rx_word_t        push_word;
    logic            exp_par;
    logic            perr_c;

    // Decision point: third of the three samples around mid-bit.
    assign mid = tick && (os_cnt == S2);
    assign maj = (smp[0] & smp[1]) |
                 (smp[0] & rx_s2) |
                 (smp[1] & rx_s2);

    // Unused upper data bits are zero, so they do not affect parity.
    assign exp_par = (cfg_prty == PRTY_EVEN) ? ^shreg : ~^shreg;
    assign perr_c  = prty_en(cfg_prty) && (par_bit != exp_par);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            arm       <= 1'b0;
            os_cnt    <= '0;
            smp       <= '0;
            bit_cnt   <= '0;
            cfg_last  <= '0;
            cfg_prty  <= PRTY_NONE;
            cfg_stop2 <= 1'b0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            ones      <= 1'b0;
            ferr      <= 1'b0;
            stop_cnt  <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
        end else begin
            push <= 1'b0;
            if (tick) begin
                os_cnt <= (os_cnt == SL) ? '0 : os_cnt + 1'b1;
                if (os_cnt == S0) smp[0] <= rx_s2;
                if (os_cnt == S1) smp[1] <= rx_s2;
            end
            unique case (state)
                IDLE: begin
                    if (rx_s2) begin
                        arm <= 1'b1;
                    end
                    if (start_det) begin
                        state     <= START;
                        os_cnt    <= '0;
                        cfg_last  <= 3'(data_width(data_bits) - 4'd1);
                        cfg_prty  <= prty_sel;
                        cfg_stop2 <= stop_sel;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                        par_bit   <= 1'b0;
                        ones      <= 1'b0;
                        ferr      <= 1'b0;
                        stop_cnt  <= 1'b0;
                    end
                end
                START: begin
                    if (mid) begin
                        state <= maj ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shreg[bit_cnt] <= maj;
                        ones           <= ones | maj;
                        bit_cnt        <= bit_cnt + 1'b1;
                        if (bit_cnt == cfg_last) begin
                            state <= prty_en(cfg_prty) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (mid) begin
                        par_bit <= maj;
                        ones    <= ones | maj;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        if (cfg_stop2 && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                            ferr     <= ferr | !maj;
                            ones     <= ones | maj;
                        end else begin
                            push           <= 1'b1;
                            push_word.data <= shreg;
                            push_word.perr <= perr_c;
                            push_word.ferr <= ferr | !maj;
                            push_word.brk  <= !(ones | maj);
                            if (ferr || !maj) begin
                                arm <= 1'b0;
                            end
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    logic     pop;
    rx_word_t out_word;

    assign pop = rx_valid && rx_ready;

`ifdef UART_RX_FIFO_EN
    localparam int WW = $bits(rx_word_t);

    logic [WW-1:0] fifo_dout;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_word),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (rx_valid),
        .ovr   (err_ovr)
    );

    assign out_word = fifo_dout;
`else
    rx_word_t hold;
    logic     hold_vld;
    logic     ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (push && (!hold_vld || pop)) begin
                hold     <= push_word;
                hold_vld <= 1'b1;
            end else begin
                if (pop) begin
                    hold_vld <= 1'b0;
                end
                if (push) begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    assign out_word = hold;
    assign rx_valid = hold_vld;
    assign err_ovr  = ovr_q;
`endif

    assign rx_data   = out_word.data;
    assign err_prty  = out_word.perr;
    assign err_frame = out_word.ferr;
    assign brk_det   = out_word.brk;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed testbench for uart_rx_os at OSR=16, baud_div=11.
// Works with and without UART_RX_FIFO_EN.
module tb_uart_rx_os;

    localparam int BIT = 16 * 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic [1:0]  prty_sel;
    logic        stop_sel;
    logic        rx_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        err_prty;
    logic        err_frame;
    logic        brk_det;
    logic        err_ovr;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;
    int ovr_base;

    always #5 clk = ~clk;

    uart_rx_os #(
        .OSR        (16),
        .DIV_W      (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_div  (baud_div),
        .data_bits (data_bits),
        .prty_sel  (prty_sel),
        .stop_sel  (stop_sel),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_prty  (err_prty),
        .err_frame (err_frame),
        .brk_det   (brk_det),
        .err_ovr   (err_ovr),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (err_ovr) ovr_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic line_bit(input logic b);
        rx_in = b;
        repeat (BIT) @(negedge clk);
    endtask

    // pb < 0 means no parity bit; all stop bits take value sv.
    task automatic send(input logic [7:0] d, input int nb,
                        input int pb, input int ns,
                        input logic sv);
        line_bit(1'b0);
        for (int i = 0; i < nb; i++) line_bit(d[i]);
        if (pb >= 0) line_bit(pb[0]);
        for (int i = 0; i < ns; i++) line_bit(sv);
        rx_in = 1'b1;
    endtask

    task automatic take();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic chk_word(input string tag,
                            input logic [7:0] d,
                            input logic pe, input logic fe,
                            input logic bk);
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, d});
        chk({tag, "_perr"}, {31'd0, err_prty}, {31'd0, pe});
        chk({tag, "_ferr"}, {31'd0, err_frame}, {31'd0, fe});
        chk({tag, "_brk"}, {31'd0, brk_det}, {31'd0, bk});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_data"}, {24'd0, rx_data}, 32'd0);
        chk({tag, "_perr"}, {31'd0, err_prty}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, err_frame}, 32'd0);
        chk({tag, "_brk"}, {31'd0, brk_det}, 32'd0);
        chk({tag, "_ovr"}, {31'd0, err_ovr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        rx_in     = 1'b1;
        rx_ready  = 1'b0;
        baud_div  = 16'd11;
        data_bits = 2'b10;
        prty_sel  = 2'b00;
        stop_sel  = 1'b0;
        repeat (5) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 7N1 0x0F
        send(8'h0F, 7, -1, 1, 1'b1);
        chk_word("t1_7n1", 8'h0F, 1'b0, 1'b0, 1'b0);
        take();
        chk("t1_pop", {31'd0, rx_valid}, 32'd0);

        // 8E2 0x2A: three ones, even parity bit 1
        data_bits = 2'b11;
        prty_sel  = 2'b10;
        stop_sel  = 1'b1;
        send(8'h2A, 8, 1, 2, 1'b1);
        chk_word("t2_even_ok", 8'h2A, 1'b0, 1'b0, 1'b0);
        take();
        send(8'h2A, 8, 0, 2, 1'b1);
        chk_word("t2_even_bad", 8'h2A, 1'b1, 1'b0, 1'b0);
        take();

        // 8O2 0xE1: four ones, odd parity bit 1
        prty_sel = 2'b01;
        send(8'hE1, 8, 1, 2, 1'b1);
        chk_word("t3_odd_ok", 8'hE1, 1'b0, 1'b0, 1'b0);
        take();
        fork
            send(8'hE1, 8, 1, 2, 1'b1);
            begin
                repeat (3 * BIT) @(negedge clk);
                prty_sel = 2'b10;
            end
        join
        chk_word("t3_cfg_hold", 8'hE1, 1'b0, 1'b0, 1'b0);
        take();

        // 8N1 framing error, then break
        prty_sel = 2'b00;
        stop_sel = 1'b0;
        send(8'h55, 8, -1, 1, 1'b0);
        chk_word("t4_ferr", 8'h55, 1'b0, 1'b1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        take();
        rx_in = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        chk_word("t4_brk", 8'h00, 1'b0, 1'b1, 1'b1);
        take();
        repeat (3 * BIT) @(negedge clk);
        chk("t4_no_retrig_valid", {31'd0, rx_valid}, 32'd0);
        chk("t4_no_retrig_busy", {31'd0, busy}, 32'd0);
        rx_in = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Start glitch of 3 ticks
        rx_in = 1'b0;
        repeat (36) @(negedge clk);
        rx_in = 1'b1;
        chk("t5_glitch_busy", {31'd0, busy}, 32'd1);
        repeat (BIT) @(negedge clk);
        chk("t5_glitch_idle", {31'd0, busy}, 32'd0);
        chk("t5_glitch_none", {31'd0, rx_valid}, 32'd0);

        // Reset mid-DATA with a word held
        send(8'hA5, 8, -1, 1, 1'b1);
        chk_word("t5_held", 8'hA5, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (BIT) @(negedge clk);
        rx_in = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        chk("t5_mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("t5_rst");
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);

        // Overrun
        ovr_base = ovr_cnt;
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 9; i++) begin
            send(8'(8'h30 + i), 8, -1, 1, 1'b1);
        end
        repeat (4) @(negedge clk);
        chk("t6_ovr_once", 32'(ovr_cnt - ovr_base), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t6_fifo_valid", {31'd0, rx_valid}, 32'd1);
            chk("t6_fifo_data", {24'd0, rx_data},
                32'(8'h30 + i));
            take();
        end
        chk("t6_fifo_empty", {31'd0, rx_valid}, 32'd0);
`else
        send(8'h11, 8, -1, 1, 1'b1);
        send(8'h22, 8, -1, 1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_ovr_once", 32'(ovr_cnt - ovr_base), 32'd1);
        chk_word("t6_kept", 8'h11, 1'b0, 1'b0, 1'b0);
        take();
        chk("t6_empty", {31'd0, rx_valid}, 32'd0);
`endif
        chk("t6_ovr_final", 32'(ovr_cnt - ovr_base), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
